// File: rtl/alu_pkg.sv
// Shared ALU op-codes and the arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers the last winner so a tie goes to the other side.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_lastGnt;

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = r_lastGnt ? 2'b01 : 2'b10;
    end
  end

  // Reset to 1 so requester 0 wins the very first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lastGnt <= 1'b1;
    end else if (i_accept) begin
      r_lastGnt <= o_grant[1];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between two valid/ready requesters,
// registering operands out and the result back so the ALU sits on no requester path.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [OP_W-1:0]   i_req0_op,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  output logic              o_resp0_valid,
  input  logic              i_resp0_ready,
  output logic [DATA_W-1:0] o_resp0_result,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [OP_W-1:0]   i_req1_op,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  output logic              o_resp1_valid,
  input  logic              i_resp1_ready,
  output logic [DATA_W-1:0] o_resp1_result,

  output logic [OP_W-1:0]   o_alu_op,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic [DATA_W-1:0] i_alu_result
);

  state_t              r_state;
  logic                r_gnt;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_res;
  logic [1:0]          r_respValid;

  logic [1:0]          w_grant;
  logic                w_idle;
  logic                w_accept;
  logic                w_respReady;

  rr_arb2 u_rrArb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  ({i_req1_valid, i_req0_valid}),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle & (|w_grant);
  assign w_respReady = r_gnt ? i_resp1_ready : i_resp0_ready;

  assign o_req0_ready = w_idle & w_grant[0];
  assign o_req1_ready = w_idle & w_grant[1];

  assign o_resp0_valid  = r_respValid[0];
  assign o_resp1_valid  = r_respValid[1];
  assign o_resp0_result = r_res;
  assign o_resp1_result = r_res;

  // The ALU always sees the latched op, so its inputs only move on a new accept.
  assign o_alu_op = r_op;
  assign o_alu_a  = r_a;
  assign o_alu_b  = r_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_respValid <= 2'b00;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_gnt   <= w_grant[1];
            r_op    <= w_grant[1] ? i_req1_op : i_req0_op;
            r_a     <= w_grant[1] ? i_req1_a  : i_req0_a;
            r_b     <= w_grant[1] ? i_req1_b  : i_req0_b;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res       <= i_alu_result;
          r_respValid <= {r_gnt, ~r_gnt};
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (w_respReady) begin
            r_respValid <= 2'b00;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_respValid <= 2'b00;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised and directed bench for alu_share_arbiter with an ALU stand-in, a
// transaction-level timing model and a result scoreboard.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } reqItem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0Valid, req1Valid, req0Ready, req1Ready;
  logic [3:0]  req0Op, req1Op, aluOp;
  logic [31:0] req0A, req0B, req1A, req1B;
  logic        resp0Valid, resp1Valid, resp0Ready, resp1Ready;
  logic [31:0] resp0Result, resp1Result, aluA, aluB, aluResult;

  reqItem_t    pendQ0[$];
  reqItem_t    pendQ1[$];
  logic [31:0] expQ[$];
  int          accLog0[$];
  int          errors = 0;
  int          checks = 0;

  bit          inFlight   = 1'b0;
  int          who        = 0;
  int          accCycle   = 0;
  int          cyc        = 0;
  bit          lastWinner = 1'b1;
  logic [3:0]  mOp        = '0;
  logic [31:0] mA         = '0;
  logic [31:0] mB         = '0;
  logic [31:0] lastResult [2];
  bit          randomReady = 1'b0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req0_valid   (req0Valid),
    .o_req0_ready   (req0Ready),
    .i_req0_op      (req0Op),
    .i_req0_a       (req0A),
    .i_req0_b       (req0B),
    .o_resp0_valid  (resp0Valid),
    .i_resp0_ready  (resp0Ready),
    .o_resp0_result (resp0Result),
    .i_req1_valid   (req1Valid),
    .o_req1_ready   (req1Ready),
    .i_req1_op      (req1Op),
    .i_req1_a       (req1A),
    .i_req1_b       (req1B),
    .o_resp1_valid  (resp1Valid),
    .i_resp1_ready  (resp1Ready),
    .o_resp1_result (resp1Result),
    .o_alu_op       (aluOp),
    .o_alu_a        (aluA),
    .o_alu_b        (aluB),
    .i_alu_result   (aluResult)
  );

  // Behavioural ALU: also serves as the external ALU wired to the arbiter.
  function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_MUL:  return a * b;
      default:  return 32'd0;
    endcase
  endfunction

  always_comb aluResult = aluRef(aluOp, aluA, aluB);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    reqItem_t it;
    it.op = op; it.a = a; it.b = b;
    if (n == 0) pendQ0.push_back(it);
    else        pendQ1.push_back(it);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((pendQ0.size() != 0 || pendQ1.size() != 0 || inFlight) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain timeout", 32'(n >= budget), 32'd0);
  endtask

  // Requester drivers: hold each item until its handshake, then present the next one.
  initial begin
    bit hs0, hs1;
    req0Valid = 0; req1Valid = 0;
    req0Op = 0; req0A = 0; req0B = 0;
    req1Op = 0; req1A = 0; req1B = 0;
    forever begin
      @(negedge clk);
      hs0 = !rst && req0Valid && req0Ready;
      hs1 = !rst && req1Valid && req1Ready;
      @(posedge clk);
      #1;
      if (hs0 && pendQ0.size() > 0) void'(pendQ0.pop_front());
      if (hs1 && pendQ1.size() > 0) void'(pendQ1.pop_front());
      req0Valid = (pendQ0.size() > 0);
      req1Valid = (pendQ1.size() > 0);
      if (req0Valid) {req0Op, req0A, req0B} = pendQ0[0];
      if (req1Valid) {req1Op, req1A, req1B} = pendQ1[0];
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (randomReady) begin
      resp0Ready = 1'($urandom_range(0, 1));
      resp1Ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: predicts handshake timing and results from the protocol rules and compares.
  initial forever begin
    bit e0, e1, r0, r1;
    logic [31:0] rsp;
    @(negedge clk);
    if (rst) begin
      inFlight = 0; lastWinner = 1; expQ.delete();
      mOp = '0; mA = '0; mB = '0;
    end else begin
      cyc++;
      e0 = !inFlight && req0Valid && (!req1Valid || lastWinner);
      e1 = !inFlight && req1Valid && (!req0Valid || !lastWinner);
      r0 = inFlight && who == 0 && cyc >= accCycle + 2;
      r1 = inFlight && who == 1 && cyc >= accCycle + 2;
      checkOutput("req0_ready", 32'(req0Ready), 32'(e0));
      checkOutput("req1_ready", 32'(req1Ready), 32'(e1));
      checkOutput("resp0_valid", 32'(resp0Valid), 32'(r0));
      checkOutput("resp1_valid", 32'(resp1Valid), 32'(r1));
      checkOutput("alu_op", 32'(aluOp), 32'(mOp));
      checkOutput("alu_a", aluA, mA);
      checkOutput("alu_b", aluB, mB);
      if (r0 || r1) begin
        rsp = r0 ? resp0Result : resp1Result;
        checkOutput(r0 ? "resp0_result" : "resp1_result", rsp, expQ[0]);
        if ((r0 && resp0Ready) || (r1 && resp1Ready)) begin
          lastResult[who] = rsp;
          void'(expQ.pop_front());
          inFlight = 0;
        end
      end
      if (e0 || e1) begin
        inFlight   = 1;
        who        = e1 ? 1 : 0;
        accCycle   = cyc;
        lastWinner = e1;
        mOp = e1 ? req1Op : req0Op;
        mA  = e1 ? req1A  : req0A;
        mB  = e1 ? req1B  : req0B;
        expQ.push_back(aluRef(mOp, mA, mB));
        if (e0) accLog0.push_back(cyc);
      end
    end
  end

  initial begin
    int n;
    rst = 1; resp0Ready = 1; resp1Ready = 1;
    lastResult[0] = '0; lastResult[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    applyStimulus(0, ALU_ADD, 32'd5, 32'd7);
    waitDrain(50);
    checkOutput("add 5+7", lastResult[0], 32'd12);

    @(posedge clk); #1 rst = 1;
    applyStimulus(0, ALU_SUB, 32'd10, 32'd3);
    applyStimulus(1, ALU_XOR, 32'hF0, 32'h0F);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    waitDrain(50);
    checkOutput("tie sub", lastResult[0], 32'd7);
    checkOutput("tie xor", lastResult[1], 32'hFF);
    applyStimulus(0, ALU_MUL, 32'd6, 32'd7);
    applyStimulus(1, ALU_OR, 32'h100, 32'h1);
    waitDrain(50);
    checkOutput("second tie mul", lastResult[0], 32'd42);

    resp0Ready = 0;
    applyStimulus(0, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
    applyStimulus(1, ALU_ADD, 32'd1, 32'd1);
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(inFlight && who == 0 && cyc >= accCycle + 2) && n < 50);
    checkOutput("stall reach timeout", 32'(n >= 50), 32'd0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("stall valid", 32'(resp0Valid), 32'd1);
      checkOutput("stall result", resp0Result, 32'h00F0_1234);
      checkOutput("stall no accept", 32'(req1Ready), 32'd0);
    end
    @(posedge clk); #1 resp0Ready = 1;
    waitDrain(50);
    checkOutput("after stall req1", lastResult[1], 32'd2);

    applyStimulus(1, ALU_SRA, 32'h8000_0000, 32'd4);
    waitDrain(50);
    checkOutput("sra", lastResult[1], 32'hF800_0000);
    applyStimulus(1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF);
    waitDrain(50);
    checkOutput("sltu", lastResult[1], 32'd1);
    applyStimulus(1, 4'b1111, 32'h1234, 32'h5678);
    waitDrain(50);
    checkOutput("undefined op", lastResult[1], 32'd0);

    applyStimulus(1, ALU_ADD, 32'd100, 32'd200);
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!inFlight && n < 50);
    checkOutput("exec reach timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    repeat (4) @(posedge clk);
    checkOutput("discarded result", lastResult[1], 32'd0);
    applyStimulus(1, ALU_OR, 32'h3, 32'h30);
    waitDrain(50);
    checkOutput("post-reset req1", lastResult[1], 32'h33);
    applyStimulus(0, ALU_SLL, 32'd1, 32'd4);
    applyStimulus(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    waitDrain(50);
    checkOutput("post-reset sll", lastResult[0], 32'd16);
    checkOutput("post-reset slt", lastResult[1], 32'd1);

    accLog0.delete();
    for (int i = 0; i < 5; i++) applyStimulus(0, ALU_ADD, 32'(i), 32'd1);
    waitDrain(100);
    checkOutput("b2b count", 32'(accLog0.size()), 32'd5);
    for (int i = 1; i < accLog0.size(); i++)
      checkOutput("b2b spacing", 32'(accLog0[i] - accLog0[i-1]), 32'd3);

    randomReady = 1;
    repeat (60) begin
      applyStimulus(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    waitDrain(3000);
    randomReady = 0;
    checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
